// File: rtl/spi_pkg.sv
// Shared SPI command codes, FSM state encodings and frame geometry.
// Used by both the master controller and the slave-side FSM.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned RD_BITS    = 8;
  localparam int unsigned MISO_WAIT  = 2;
  localparam int unsigned IDLE_GAP   = 1;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned PAYLOAD_W  = FRAME_BITS - 2;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    SHIFT   = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    GAP     = 3'd5
  } state_e;

  typedef struct packed {
    cmd_e                 cmd;
    logic [PAYLOAD_W-1:0] payload;
  } cmd_word_t;

endpackage

// File: rtl/spi_master_shifter.sv
// MOSI parallel-in/serial-out, MISO serial-in/parallel-out and the shared
// down-counter that times every FSM phase.
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [FRAME_BITS-1:0] load_word,
  input  logic                  shift_en,
  input  logic                  cap_en,
  input  logic                  miso,
  input  logic                  cnt_load,
  input  logic [CNT_W-1:0]      cnt_init,
  input  logic                  cnt_dec,
  output logic                  mosi_bit_c,
  output logic [RD_BITS-1:0]    cap_next_c,
  output logic                  cnt_zero_c
);

  logic [FRAME_BITS-1:0] word_q;
  logic [RD_BITS-2:0]    cap_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cap_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (load_en) begin
        word_q <= load_word;
      end else if (shift_en) begin
        word_q <= {word_q[FRAME_BITS-2:0], 1'b0};
      end
      if (cap_en) begin
        cap_q <= cap_next_c[RD_BITS-2:0];
      end
      if (cnt_load) begin
        cnt_q <= cnt_init;
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // The completed byte is exposed combinationally so the last sample lands in rsp_data directly.
  assign mosi_bit_c = word_q[FRAME_BITS-1];
  assign cap_next_c = {cap_q, miso};
  assign cnt_zero_c = (cnt_q == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: accepts 10-bit host commands, frames them on SS_n/MOSI and
// returns the MISO byte for read-data commands.
module spi_master_ctrl
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [FRAME_BITS-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [RD_BITS-1:0]    rsp_data,
  output logic                  busy,
  output logic                  SS_n,
  output logic                  MOSI,
  input  logic                  MISO
);

  state_e     state_q, state_d;
  logic       is_rd_q, is_rd_d;
  logic       ss_n_d, mosi_d, ready_d, busy_d, rsp_valid_d, rsp_load;
  logic       load_en, shift_en, cap_en, cnt_load, cnt_dec;
  logic [CNT_W-1:0] cnt_init;
  logic       mosi_bit_c, cnt_zero_c;
  logic [RD_BITS-1:0] cap_next_c;
  cmd_word_t  cmd_w;
  logic       accept_c;

  assign cmd_w    = cmd_data;
  assign accept_c = cmd_valid && cmd_ready;

  spi_master_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_word  (cmd_w),
    .shift_en   (shift_en),
    .cap_en     (cap_en),
    .miso       (MISO),
    .cnt_load   (cnt_load),
    .cnt_init   (cnt_init),
    .cnt_dec    (cnt_dec),
    .mosi_bit_c (mosi_bit_c),
    .cap_next_c (cap_next_c),
    .cnt_zero_c (cnt_zero_c)
  );

  // Next state and next-cycle output values; outputs are registered from these.
  always_comb begin
    state_d     = state_q;
    is_rd_d     = is_rd_q;
    ss_n_d      = 1'b1;
    mosi_d      = 1'b0;
    ready_d     = 1'b0;
    busy_d      = 1'b1;
    rsp_valid_d = 1'b0;
    rsp_load    = 1'b0;
    load_en     = 1'b0;
    shift_en    = 1'b0;
    cap_en      = 1'b0;
    cnt_load    = 1'b0;
    cnt_init    = '0;
    cnt_dec     = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (accept_c) begin
          state_d  = START;
          is_rd_d  = (cmd_w.cmd == CMD_RD_DATA);
          ss_n_d   = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          load_en  = 1'b1;
          cnt_load = 1'b1;
          cnt_init = CNT_W'(FRAME_BITS);
        end
      end
      START: begin
        state_d  = SHIFT;
        ss_n_d   = 1'b0;
        mosi_d   = mosi_bit_c;
        shift_en = 1'b1;
        cnt_dec  = 1'b1;
      end
      SHIFT: begin
        ss_n_d = 1'b0;
        if (cnt_zero_c) begin
          cnt_load = 1'b1;
          if (is_rd_q) begin
            state_d  = WAIT;
            cnt_init = CNT_W'(MISO_WAIT - 1);
          end else begin
            state_d  = GAP;
            ss_n_d   = 1'b1;
            cnt_init = CNT_W'(IDLE_GAP - 1);
          end
        end else begin
          mosi_d   = mosi_bit_c;
          shift_en = 1'b1;
          cnt_dec  = 1'b1;
        end
      end
      WAIT: begin
        ss_n_d = 1'b0;
        if (cnt_zero_c) begin
          state_d  = CAPTURE;
          cnt_load = 1'b1;
          cnt_init = CNT_W'(RD_BITS - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      CAPTURE: begin
        cap_en = 1'b1;
        if (cnt_zero_c) begin
          state_d     = GAP;
          rsp_valid_d = 1'b1;
          rsp_load    = 1'b1;
          cnt_load    = 1'b1;
          cnt_init    = CNT_W'(IDLE_GAP - 1);
        end else begin
          ss_n_d  = 1'b0;
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero_c) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      is_rd_q   <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_d;
      is_rd_q   <= is_rd_d;
      SS_n      <= ss_n_d;
      MOSI      <= mosi_d;
      cmd_ready <= ready_d;
      busy      <= busy_d;
      rsp_valid <= rsp_valid_d;
      if (rsp_load) begin
        rsp_data <= cap_next_c;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed and randomized checks of spi_master_ctrl against a cycle-offset
// frame model and a small behavioural slave RAM.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int WR_LEN = 12 + int'(IDLE_GAP);
  localparam int RD_RSP = 12 + int'(MISO_WAIT) + int'(RD_BITS);
  localparam int RD_LEN = RD_RSP + int'(IDLE_GAP);

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  int vectors;
  int miscompares;

  logic [7:0] mem [256];
  logic [7:0] wr_addr;
  logic [7:0] rd_addr;
  logic [7:0] exp_rsp;

  spi_master_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_ss_n"}, SS_n, 1'b1);
    chk1({tag, "_mosi"}, MOSI, 1'b0);
    chk1({tag, "_ready"}, cmd_ready, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk8({tag, "_rsp_data"}, rsp_data, 8'h00);
  endtask

  // Behavioural slave RAM: returns the byte a read-data frame should carry back.
  task automatic slave_model(input logic [9:0] word, output logic [7:0] reply);
    reply = 8'h00;
    case (word[9:8])
      2'b00:   wr_addr = word[7:0];
      2'b01:   mem[wr_addr] = word[7:0];
      2'b10:   rd_addr = word[7:0];
      default: reply = mem[rd_addr];
    endcase
  endtask

  // One host command: offer it, then check every cycle k after the accept edge.
  task automatic run_frame(input logic [9:0] word, input logic [7:0] reply,
                           input bit hold, input int abort_k, input int pulse_k);
    bit   rd;
    int   len;
    int   w;
    int   mi;
    int   ci;
    logic exp_ss, exp_mosi;
    rd  = (word[9:8] == 2'b11);
    len = rd ? RD_LEN : WR_LEN;
    w   = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk1("ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_data  = word;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) cmd_valid = 1'b0;
      exp_ss   = rd ? (k >= RD_RSP) : (k >= 12);
      mi       = 11 - k;
      exp_mosi = (k >= 2 && k <= 11) ? word[mi[3:0]] : 1'b0;
      if (rd && k == RD_RSP) exp_rsp = reply;
      chk1("ss_n", SS_n, exp_ss);
      chk1("mosi", MOSI, exp_mosi);
      chk1("busy", busy, k < len);
      chk1("cmd_ready", cmd_ready, k == len);
      chk1("rsp_valid", rsp_valid, rd && k == RD_RSP);
      chk8("rsp_data", rsp_data, exp_rsp);
      ci = RD_RSP - 1 - k;
      if (rd && k >= RD_RSP - int'(RD_BITS) && k < RD_RSP) MISO = reply[ci[2:0]];
      else MISO = 1'($urandom_range(0, 1));
      if (pulse_k != 0 && k == pulse_k) begin
        cmd_valid = 1'b1;
        cmd_data  = 10'($urandom);
      end
      if (pulse_k != 0 && k == pulse_k + 1) cmd_valid = 1'b0;
      if (k == abort_k) begin
        rst = 1'b1;
        @(negedge clk);
        exp_rsp = 8'h00;
        chk_reset_outputs("abort");
        rst = 1'b0;
        @(negedge clk);
        chk1("abort_ready_back", cmd_ready, 1'b1);
        chk1("abort_no_rsp", rsp_valid, 1'b0);
        return;
      end
    end
  endtask

  task automatic host_cmd(input logic [9:0] word, input bit hold, input int abort_k, input int pulse_k);
    logic [7:0] reply;
    slave_model(word, reply);
    run_frame(word, reply, hold, abort_k, pulse_k);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      MISO = 1'($urandom_range(0, 1));
      chk1("idle_ss_n", SS_n, 1'b1);
      chk1("idle_mosi", MOSI, 1'b0);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_ready", cmd_ready, 1'b1);
      chk1("idle_rsp_valid", rsp_valid, 1'b0);
      chk8("idle_rsp_data", rsp_data, exp_rsp);
    end
  endtask

  function automatic logic [9:0] rand_word();
    logic [1:0] c;
    logic [7:0] p;
    c = 2'($urandom_range(0, 3));
    p = (c == 2'b00 || c == 2'b10) ? 8'($urandom_range(0, 7)) : 8'($urandom);
    return {c, p};
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_data    = '0;
    MISO        = 1'b0;
    wr_addr     = '0;
    rd_addr     = '0;
    exp_rsp     = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // Reset values, then cmd_ready one cycle after release.
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("reset");
    end
    rst = 1'b0;
    @(negedge clk);
    chk1("ready_after_rst", cmd_ready, 1'b1);
    chk1("busy_after_rst", busy, 1'b0);

    // Basic write frame bit order and turnaround.
    host_cmd(10'b00_1010_0101, 1'b0, 0, 0);

    // Write/read round trip through the slave RAM.
    host_cmd({2'b00, 8'h3C}, 1'b0, 0, 0);
    host_cmd({2'b01, 8'h5A}, 1'b0, 0, 0);
    host_cmd({2'b10, 8'h3C}, 1'b0, 0, 0);
    host_cmd({2'b11, 8'h00}, 1'b0, 0, 0);
    chk8("roundtrip_rsp", rsp_data, 8'h5A);
    idle_check(2);

    // cmd_valid held across four back-to-back commands.
    host_cmd(rand_word(), 1'b1, 0, 0);
    host_cmd({2'b11, 8'($urandom)}, 1'b1, 0, 0);
    host_cmd(rand_word(), 1'b1, 0, 0);
    host_cmd(rand_word(), 1'b0, 0, 0);
    idle_check(3);

    // cmd_valid pulses while busy are ignored.
    host_cmd({2'b01, 8'($urandom)}, 1'b0, 0, 5);
    idle_check(3);
    host_cmd({2'b11, 8'($urandom)}, 1'b0, 0, 15);
    idle_check(3);

    // Reset during SHIFT bit 5 of a read-data frame, then a clean read.
    host_cmd({2'b10, 8'h05}, 1'b0, 0, 0);
    host_cmd({2'b11, 8'hA7}, 1'b0, 6, 0);
    idle_check(1);
    host_cmd({2'b11, 8'h00}, 1'b0, 0, 0);
    idle_check(1);

    // Fixed MISO pattern 1,0,0,1,1,1,0,0.
    run_frame({2'b11, 8'h00}, 8'h9C, 1'b0, 0, 0);
    chk8("standalone_rsp", rsp_data, 8'h9C);
    idle_check(1);

    // Randomized command stream with random idle spacing.
    for (int n = 0; n < 30; n++) begin
      host_cmd(rand_word(), 1'b0, 0, 0);
      idle_check(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
